// File: rtl/softmax_exp_seq.sv
// ============================================================================
// softmax_exp_seq : buffers one row of Q2.13 scores, then streams exp(x-max)
//                   with the row sum through one shared combinational exp unit.
// Revision        : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module exp_x (
  input  logic [15:0] x_i,
  output logic [15:0] y_o
);
  // e^x = 2^(x*log2e): integer part becomes a shift, fraction goes to a
  // 32-segment interpolated 2^f table held in Q1.15.
  localparam logic signed [33:0] c_LOG2E = 34'sd47274;

  logic signed [33:0] w_xs;
  logic signed [33:0] w_prod;
  logic signed [23:0] w_y;
  logic signed [5:0]  w_n;
  logic [4:0]         w_k;
  logic [12:0]        w_lo;
  logic [16:0]        w_l0;
  logic [16:0]        w_l1;
  logic [23:0]        w_dprod;
  logic [16:0]        w_val;
  logic [5:0]         w_sh;
  logic [40:0]        w_rnd;
  logic               w_sat;
  logic               w_unused;

  function automatic logic [16:0] pow2_lut(input logic [5:0] k);
    logic [16:0] v;
    case (k)
      6'd0:  v = 17'd32768;  6'd1:  v = 17'd33486;  6'd2:  v = 17'd34219;
      6'd3:  v = 17'd34968;  6'd4:  v = 17'd35734;  6'd5:  v = 17'd36516;
      6'd6:  v = 17'd37316;  6'd7:  v = 17'd38133;  6'd8:  v = 17'd38968;
      6'd9:  v = 17'd39821;  6'd10: v = 17'd40693;  6'd11: v = 17'd41584;
      6'd12: v = 17'd42495;  6'd13: v = 17'd43425;  6'd14: v = 17'd44376;
      6'd15: v = 17'd45348;  6'd16: v = 17'd46341;  6'd17: v = 17'd47356;
      6'd18: v = 17'd48393;  6'd19: v = 17'd49452;  6'd20: v = 17'd50535;
      6'd21: v = 17'd51642;  6'd22: v = 17'd52773;  6'd23: v = 17'd53928;
      6'd24: v = 17'd55109;  6'd25: v = 17'd56316;  6'd26: v = 17'd57549;
      6'd27: v = 17'd58809;  6'd28: v = 17'd60097;  6'd29: v = 17'd61413;
      6'd30: v = 17'd62757;  6'd31: v = 17'd64132;
      default: v = 17'd65536;
    endcase
    return v;
  endfunction

  assign w_xs    = {{18{x_i[15]}}, x_i};
  assign w_prod  = w_xs * c_LOG2E;
  assign w_y     = w_prod[33:10];
  assign w_n     = w_y[23:18];
  assign w_k     = w_y[17:13];
  assign w_lo    = w_y[12:0];
  assign w_l0    = pow2_lut({1'b0, w_k});
  assign w_l1    = pow2_lut({1'b0, w_k} + 6'd1);
  assign w_dprod = {7'd0, w_l1 - w_l0} * {11'd0, w_lo};
  assign w_val   = w_l0 + {6'd0, w_dprod[23:13]};
  assign w_sat   = (w_n >= 6'sd2);
  assign w_sh    = 6'd2 - w_n;
  assign w_rnd   = ({24'd0, w_val} + (41'd1 << (w_sh - 6'd1))) >> w_sh;
  assign y_o     = w_sat ? 16'h8000 : w_rnd[15:0];

  assign w_unused = ^{w_prod[9:0], w_rnd[40:16]};
endmodule

module softmax_exp_seq #(
  parameter int D  = 16,
  parameter int AW = $clog2(D)
) (
  input  logic            I_CLK,
  input  logic            I_RST,
  input  logic            I_IN_VALID,
  input  logic [15:0]     I_IN_DATA,
  output logic            O_IN_READY,
  output logic            O_OUT_VALID,
  output logic [15:0]     O_OUT_DATA,
  output logic            O_OUT_LAST,
  input  logic            I_OUT_READY,
  output logic [16+AW-1:0] O_SUM,
  output logic            O_SUM_VALID,
  output logic            O_BUSY
);
  localparam int SW = 16 + AW;
  localparam logic [AW-1:0] LAST_IDX = AW'(D - 1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_EXP  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic signed [15:0]  mx_q, mx_d;
  logic [SW-1:0]       acc_q, acc_d;
  logic [15:0]         buf_q [D];
  logic                buf_we;
  logic [15:0]         buf_wdata;

  logic [15:0]         w_rd;
  logic signed [16:0]  w_diff;
  logic [15:0]         w_exp_in;
  logic [15:0]         w_exp;
  logic                w_last;

  assign w_rd   = buf_q[idx_q];
  assign w_last = (idx_q == LAST_IDX);
  assign w_diff = {w_rd[15], w_rd} - {mx_q[15], mx_q};

  // Differences below -4.0 saturate to the most negative Q2.13 code.
  always_comb begin
    w_exp_in = w_diff[15:0];
    if (w_diff[16] != w_diff[15]) begin
      w_exp_in = w_diff[16] ? 16'h8000 : 16'h7FFF;
    end
  end

  exp_x u_exp (
    .x_i (w_exp_in),
    .y_o (w_exp)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    mx_d      = mx_q;
    acc_d     = acc_q;
    buf_we    = 1'b0;
    buf_wdata = I_IN_DATA;
    case (state_q)
      ST_LOAD: begin
        if (I_IN_VALID) begin
          buf_we = 1'b1;
          if ($signed(I_IN_DATA) > mx_q) mx_d = $signed(I_IN_DATA);
          idx_d = idx_q + ONE_IDX;
          if (w_last) begin
            idx_d   = '0;
            state_d = ST_EXP;
          end
        end
      end
      ST_EXP: begin
        buf_we    = 1'b1;
        buf_wdata = w_exp;
        acc_d     = acc_q + {{AW{1'b0}}, w_exp};
        idx_d     = idx_q + ONE_IDX;
        if (w_last) begin
          idx_d   = '0;
          state_d = ST_OUT;
        end
      end
      ST_OUT: begin
        if (I_OUT_READY) begin
          idx_d = idx_q + ONE_IDX;
          if (w_last) begin
            idx_d   = '0;
            mx_d    = 16'sh8000;
            acc_d   = '0;
            state_d = ST_LOAD;
          end
        end
      end
      default: begin
        idx_d   = '0;
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge I_CLK) begin
    if (I_RST) begin
      state_q <= ST_LOAD;
      idx_q   <= '0;
      mx_q    <= 16'sh8000;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mx_q    <= mx_d;
      acc_q   <= acc_d;
    end
  end

  always_ff @(posedge I_CLK) begin
    if (buf_we) buf_q[idx_q] <= buf_wdata;
  end

  always_comb begin
    O_IN_READY  = (state_q == ST_LOAD);
    O_OUT_VALID = (state_q == ST_OUT);
    O_OUT_LAST  = (state_q == ST_OUT) && w_last;
    O_SUM_VALID = (state_q == ST_OUT);
    O_BUSY      = (state_q != ST_LOAD);
    O_OUT_DATA  = w_rd;
    O_SUM       = acc_q;
  end
endmodule

`default_nettype wire

// File: tb/tb_softmax_exp_seq.sv
// ============================================================================
// tb_softmax_exp_seq : scoreboard bench for the softmax exp row sequencer.
// Revision           : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_softmax_exp_seq;
  localparam int D  = 16;
  localparam int AW = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [15:0]       in_data;
  logic              in_ready;
  logic              out_valid;
  logic [15:0]       out_data;
  logic              out_last;
  logic              out_ready;
  logic [16+AW-1:0]  sum;
  logic              sum_valid;
  logic              busy;

  always #5 clk = ~clk;

  softmax_exp_seq #(.D(D), .AW(AW)) dut (
    .I_CLK       (clk),
    .I_RST       (rst),
    .I_IN_VALID  (in_valid),
    .I_IN_DATA   (in_data),
    .O_IN_READY  (in_ready),
    .O_OUT_VALID (out_valid),
    .O_OUT_DATA  (out_data),
    .O_OUT_LAST  (out_last),
    .I_OUT_READY (out_ready),
    .O_SUM       (sum),
    .O_SUM_VALID (sum_valid),
    .O_BUSY      (busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input longint obs, input longint expv, input longint tol);
    longint diff;
    n_checks++;
    diff = (obs > expv) ? obs - expv : expv - obs;
    if (diff > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (tol %0d) at cycle %0d", tag, obs, expv, tol, cyc);
    end
  endtask

  typedef struct {
    logic [15:0] data;
    int          tol;
    logic        last;
  } el_t;

  el_t          q_el[$];
  int           q_sum[$];
  int           q_sum_tol[$];
  logic [15:0]  row_buf [D];
  int           accept_cyc = 0;
  bit           lat_chk = 1'b0;
  int           ready_mode = 0;
  int           garbage_pct = 0;

  // Reference model: real-valued exp of the clamped difference to the row max.
  task automatic push_expected();
    int  mx;
    int  d;
    real e;
    real s;
    bit  all0;
    el_t el;
    mx   = -32768;
    s    = 0.0;
    all0 = 1'b1;
    for (int i = 0; i < D; i++) begin
      if (int'($signed(row_buf[i])) > mx) mx = int'($signed(row_buf[i]));
    end
    for (int i = 0; i < D; i++) begin
      d = int'($signed(row_buf[i])) - mx;
      if (d < -32768) d = -32768;
      e = $exp(real'(d) / 8192.0) * 8192.0;
      s = s + e;
      el.data = 16'($rtoi(e + 0.5));
      el.tol  = (d == 0) ? 0 : 8;
      el.last = (i == D - 1);
      if (d != 0) all0 = 1'b0;
      q_el.push_back(el);
    end
    q_sum.push_back($rtoi(s + 0.5));
    q_sum_tol.push_back(all0 ? 0 : 128);
  endtask

  task automatic send_row(input bit push, input int bubble_pct);
    int i;
    int guard;
    i = 0;
    guard = 0;
    if (push) push_expected();
    while (i < D && guard < 4000) begin
      @(posedge clk); #1;
      guard++;
      if (in_ready) begin
        in_valid = ($urandom_range(0, 99) >= bubble_pct);
        in_data  = row_buf[i];
        if (in_valid) begin
          if (i == D - 1) accept_cyc = cyc + 1;
          i++;
        end
      end else begin
        in_valid = ($urandom_range(0, 99) < garbage_pct);
        in_data  = 16'($urandom);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (i != D) check_val("send_timeout", i, D, 0);
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (q_el.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    check_val("drain", q_el.size(), 0, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out_ready = (ready_mode == 0) ? 1'b1 : ~out_ready;
    end
  end

  bit          stall_prev = 1'b0;
  bit          valid_prev = 1'b0;
  logic [15:0] prev_data;
  logic        prev_last;
  logic [16+AW-1:0] prev_sum;
  el_t         mon_el;

  always @(negedge clk) begin
    if (!rst) begin
      if (busy && in_valid) check_val("in_ready_busy", in_ready, 0, 0);
      if (stall_prev) begin
        check_val("stall_data", out_data, prev_data, 0);
        check_val("stall_last", out_last, prev_last, 0);
        check_val("stall_sum", sum, prev_sum, 0);
      end
      if (out_valid && !valid_prev && lat_chk) begin
        check_val("latency", cyc - accept_cyc, D, 0);
        lat_chk = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (q_el.size() == 0) begin
          check_val("spurious_out", 1, 0, 0);
        end else begin
          mon_el = q_el.pop_front();
          check_val("out_data", out_data, mon_el.data, mon_el.tol);
          check_val("out_last", out_last, mon_el.last, 0);
          if (mon_el.last) begin
            check_val("sum_valid", sum_valid, 1, 0);
            if (q_sum.size() == 0) check_val("spurious_sum", 1, 0, 0);
            else check_val("row_sum", sum, q_sum.pop_front(), q_sum_tol.pop_front());
          end
        end
      end
      stall_prev = out_valid && !out_ready;
      valid_prev = out_valid;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_sum   = sum;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", in_ready, 1, 0);
    check_val("rst_out_valid", out_valid, 0, 0);
    check_val("rst_out_last", out_last, 0, 0);
    check_val("rst_sum_valid", sum_valid, 0, 0);
    check_val("rst_sum", sum, 0, 0);
    check_val("rst_busy", busy, 0, 0);
    rst = 1'b0;

    // All-zero row with latency measurement
    for (int i = 0; i < D; i++) row_buf[i] = 16'h0000;
    lat_chk = 1'b1;
    send_row(1'b1, 0);
    wait_drain(200);
    check_val("latency_seen", lat_chk, 0, 0);

    // Single 0.5 at index 7
    for (int i = 0; i < D; i++) row_buf[i] = 16'h0000;
    row_buf[7] = 16'h1000;
    send_row(1'b1, 0);
    wait_drain(200);

    // Clamp path
    for (int i = 0; i < D; i++) row_buf[i] = 16'h7FFF;
    row_buf[1] = 16'h8000;
    send_row(1'b1, 0);
    wait_drain(200);

    // Backpressure with input bubbles and ignored valid pulses
    ready_mode  = 1;
    garbage_pct = 40;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < D; i++) begin
        if (r == 0) row_buf[i] = 16'($urandom_range(0, 65535));
        else        row_buf[i] = 16'($urandom_range(0, 16383) - 8192);
      end
      send_row(1'b1, 30);
    end
    wait_drain(1000);
    ready_mode  = 0;
    garbage_pct = 0;
    @(posedge clk); #1;

    // Reset while EXP is processing element 5
    for (int i = 0; i < D; i++) row_buf[i] = 16'h0000;
    send_row(1'b0, 0);
    while (cyc < accept_cyc + 5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_val("mid_rst_in_ready", in_ready, 1, 0);
    check_val("mid_rst_out_valid", out_valid, 0, 0);
    check_val("mid_rst_sum", sum, 0, 0);
    check_val("mid_rst_busy", busy, 0, 0);
    send_row(1'b1, 0);
    wait_drain(200);

    // Back-to-back: negative row, then a mixed row
    for (int i = 0; i < D; i++) row_buf[i] = 16'hC000;
    send_row(1'b1, 0);
    for (int i = 0; i < D; i++) row_buf[i] = 16'(i * 16'h0400 - 16'h2000);
    send_row(1'b1, 0);
    wait_drain(300);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

`default_nettype wire
